imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the core's fetch port: accepts a fetch PC, returns the 32-bit instruction word after a fixed, parameterised latency, and flags misaligned or out-of-range fetches. It sits between the core (fetch initiator, reset PC 0x80000000) and a word-addressed instruction store. The store is filled through a separate loader write port by the testbench or boot logic. One fetch is outstanding at a time, with valid/ready handshakes on both request and response.

## Interface
- ADDR_WIDTH, 10: word-index width; store depth = 2^ADDR_WIDTH words.
- BASE, 32'h80000000: byte address of word 0.
- LATENCY, 2: cycles from request acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  responder can accept a request.
- req_pc  in  32  fetch byte address.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  core accepts response.
- rsp_inst  out  32  instruction word (0 when rsp_err).
- rsp_err  out  1  fetch fault (misaligned or out of range).
- ld_en  in  1  loader write enable.
- ld_addr  in  ADDR_WIDTH  loader word index.
- ld_data  in  32  loader write data.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1, rsp_valid=0.
  - On req_valid&req_ready, capture req_pc. Go to RESP if LATENCY=1, otherwise to WAIT with the counter loaded to LATENCY-2.
- WAIT: req_ready=0. Decrement the counter each cycle; go to RESP on the cycle the counter is 0.
- Any transition into RESP registers rsp_inst and rsp_err from the captured PC, sampled on that same edge.
- RESP: rsp_valid=1, req_ready=0.
  - rsp_inst and rsp_err hold stable until rsp_valid&rsp_ready.
  - On handshake, go to IDLE.
- Decode of captured PC: off = pc - BASE (32-bit, unsigned).
  - Misaligned: pc[1:0] != 0.
  - Out of range: pc < BASE, or off[31:2] >= 2^ADDR_WIDTH.
  - Either condition sets rsp_err=1 and rsp_inst=0.
  - Otherwise rsp_inst = mem[off[ADDR_WIDTH+1:2]] and rsp_err=0.
- Loader:
  - When ld_en=1, mem[ld_addr] <= ld_data on the rising edge, in any state.
  - If the write targets the word being sampled into rsp_inst on the same edge, the response carries the old value (read-before-write).
- Store contents are not reset; contents are undefined until loaded.
- req_pc and req_valid are ignored outside IDLE.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, counter=0. Outputs take these values immediately on rst assertion, with no clock required.
- Reset mid-transaction (WAIT or RESP) abandons the fetch. No response is produced after rst deasserts.
- Latency: a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Throughput: if the response is consumed at edge M, req_ready=1 after edge M and the next request can be accepted at edge M+1. Peak rate is one fetch per LATENCY+1 cycles.
- Backpressure: rsp_ready held low keeps state RESP indefinitely, with outputs unchanged.
- req_ready and rsp_valid are decoded from state only. They never depend combinationally on req_valid or rsp_ready.

## Test plan
- Reset and first fetch:
  - Stimulus: load mem[0]=32'h00000413; assert rst mid-cycle; release; request pc=0x80000000 with rsp_ready=1.
  - Required: outputs are zero asynchronously during rst; rsp_valid asserts exactly 2 cycles after acceptance with rsp_inst=0x00000413, rsp_err=0.
- Sequential fetches at peak rate:
  - Stimulus: load words 0..3 with 0x11111111..0x44444444; request pc=0x80000000, +4, +8, +C back-to-back.
  - Required: responses arrive in order with matching data, one every 3 cycles (LATENCY=2).
- Faults:
  - Stimulus: request pc=0x80000002, then 0x7FFFFFFC, then 0x80001000 (ADDR_WIDTH=10).
  - Required: each returns rsp_err=1, rsp_inst=0.
  - Stimulus: then request pc=0x80000FFC with mem[1023]=0xDEADBEEF.
  - Required: rsp_err=0, rsp_inst=0xDEADBEEF.
- Backpressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles in RESP; toggle req_valid and req_pc meanwhile.
  - Required: rsp_valid stays 1 and rsp_inst is unchanged; req_ready=0 throughout; no extra request is accepted.
- Loader collision:
  - Stimulus: mem[5]=0xAAAAAAAA; fetch pc=0x80000014; write ld_addr=5, ld_data=0xBBBBBBBB on the sampling edge.
  - Required: response is 0xAAAAAAAA; an immediate refetch returns 0xBBBBBBBB.
- Reset mid-operation and LATENCY=1 build:
  - Stimulus: assert rst while in WAIT.
  - Required: rsp_valid is never asserted for that fetch.
  - Stimulus: with LATENCY=1, accept a request at edge N.
  - Required: rsp_valid=1 after edge N.

Source files
------------

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch port.
// Single outstanding fetch, fixed latency, fault flag on bad PCs.
module imem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_nx;

  logic [3:0]            cnt, cnt_nx;
  logic [31:0]           pc_q, pc_nx;
  logic [31:0]           dec_pc;
  logic [31:0]           off;
  logic                  bad;
  logic                  load_rsp;
  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            unused_off;

  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pc_nx     = pc_q;
    dec_pc    = pc_q;
    load_rsp  = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          pc_nx  = req_pc;
          dec_pc = req_pc;
          if (LATENCY == 1) begin
            state_nx = RESP;
            load_rsp = 1'b1;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = RESP;
          load_rsp = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Word offset must fit the store; high offset bits flag out-of-range.
  assign off        = dec_pc - BASE;
  assign idx        = off[ADDR_WIDTH+1:2];
  assign unused_off = off[1:0];
  assign bad        = (dec_pc[1:0] != 2'b00)
                    | (dec_pc < BASE)
                    | (|off[31:ADDR_WIDTH+2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      cnt      <= '0;
      rsp_inst <= '0;
      rsp_err  <= 1'b0;
    end else begin
      pc_q <= pc_nx;
      cnt  <= cnt_nx;
      if (load_rsp) begin
        rsp_err  <= bad;
        rsp_inst <= bad ? 32'h0 : mem[idx];
      end
    end
  end

  // Store is not reset; a same-edge write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder.
// Scoreboard queue of expected responses, per-feature test tasks.
module tb_imem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_pc = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [31:0] req_pc1 = '0;
  logic        rsp_valid1;
  logic        rsp_ready1 = 1'b1;
  logic [31:0] rsp_inst1;
  logic        rsp_err1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [1024];
  logic [32:0] sb [$];

  imem_responder #(
    .ADDR_WIDTH(10), .BASE(BASE), .LATENCY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(
    .ADDR_WIDTH(10), .BASE(BASE), .LATENCY(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_pc(req_pc1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_inst(rsp_inst1), .rsp_err(rsp_err1),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_en   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    tick();
    ld_en = 1'b0;
    model[a] = d;
  endtask

  function automatic logic [32:0] exp_of(input logic [31:0] pc);
    logic [31:0] off;
    off = pc - BASE;
    if (pc[1:0] != 2'b00 || pc < BASE || off[31:12] != 20'h0)
      return {1'b1, 32'h0};
    return {1'b0, model[off[11:2]]};
  endfunction

  task automatic send(input logic [31:0] pc, output int acc);
    int n;
    n = 0;
    req_pc    = pc;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready got=%b want=1", req_ready);
    end
    sb.push_back(exp_of(pc));
    tick();
    acc = cyc;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    at = cyc;
  endtask

  task automatic test_reset();
    int acc, at;
    logic [32:0] e;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    load(0, 32'h0000_0413);
    rsp_ready = 1'b0;
    send(BASE, acc);
    wait_rsp(at);
    void'(sb.pop_front());
    #3 rst = 1'b1;
    #1;
    checks += 4;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid);
    end
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_ready got=%b want=1", req_ready);
    end
    if (rsp_inst !== 32'h0) begin
      errors++;
      $display("FAIL rst_rsp_inst got=%h want=0", rsp_inst);
    end
    if (rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp_err got=%b want=0", rsp_err);
    end
    #2 rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    send(BASE, acc);
    wait_rsp(at);
    e = sb.pop_front();
    checks += 3;
    if (rsp_valid !== 1'b1 || at - acc != 1) begin
      errors++;
      $display("FAIL first_latency got=%0d want=1 valid=%b",
               at - acc, rsp_valid);
    end
    if (rsp_inst !== e[31:0]) begin
      errors++;
      $display("FAIL first_inst got=%h want=%h", rsp_inst, e[31:0]);
    end
    if (rsp_err !== e[32]) begin
      errors++;
      $display("FAIL first_err got=%b want=%b", rsp_err, e[32]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc [4];
    int at;
    logic [32:0] e;
    for (int i = 0; i < 4; i++)
      load(i, 32'h1111_1111 * (i + 1));
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(BASE + 32'(4 * i), acc[i]);
      wait_rsp(at);
      e = sb.pop_front();
      checks += 2;
      if (rsp_valid !== 1'b1 || rsp_inst !== e[31:0]) begin
        errors++;
        $display("FAIL b2b_inst[%0d] got=%h want=%h v=%b",
                 i, rsp_inst, e[31:0], rsp_valid);
      end
      if (rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_err[%0d] got=%b want=0", i, rsp_err);
      end
      if (i > 0) begin
        checks++;
        if (acc[i] - acc[i-1] != 3) begin
          errors++;
          $display("FAIL b2b_rate[%0d] got=%0d want=3",
                   i, acc[i] - acc[i-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] pcs [4];
    int acc, at;
    logic [32:0] e;
    pcs[0] = 32'h8000_0002;
    pcs[1] = 32'h7FFF_FFFC;
    pcs[2] = 32'h8000_1000;
    pcs[3] = 32'h8000_0FFC;
    load(1023, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      send(pcs[i], acc);
      wait_rsp(at);
      e = sb.pop_front();
      checks += 2;
      if (rsp_valid !== 1'b1 || rsp_err !== e[32]) begin
        errors++;
        $display("FAIL fault_err[%0d] got=%b want=%b v=%b",
                 i, rsp_err, e[32], rsp_valid);
      end
      if (rsp_inst !== e[31:0]) begin
        errors++;
        $display("FAIL fault_inst[%0d] got=%h want=%h",
                 i, rsp_inst, e[31:0]);
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int acc, at;
    logic [32:0] e;
    rsp_ready = 1'b0;
    send(BASE + 32'h4, acc);
    wait_rsp(at);
    e = sb.pop_front();
    for (int k = 0; k < 5; k++) begin
      req_valid = k[0];
      req_pc    = $urandom;
      tick();
      checks += 2;
      if (rsp_valid !== 1'b1 || rsp_inst !== e[31:0]) begin
        errors++;
        $display("FAIL bp_hold[%0d] got=%h want=%h v=%b",
                 k, rsp_inst, e[31:0], rsp_valid);
      end
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d] got=%b want=0", k, req_ready);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got=%b%b want=01",
               rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_extra got=%b want=0", rsp_valid);
    end
  endtask

  task automatic test_collision();
    int acc, at;
    logic [32:0] e;
    load(5, 32'hAAAA_AAAA);
    rsp_ready = 1'b1;
    send(BASE + 32'h14, acc);
    ld_en   = 1'b1;
    ld_addr = 10'd5;
    ld_data = 32'hBBBB_BBBB;
    tick();
    ld_en = 1'b0;
    model[5] = 32'hBBBB_BBBB;
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== e[31:0]) begin
      errors++;
      $display("FAIL coll_old got=%h want=%h v=%b",
               rsp_inst, e[31:0], rsp_valid);
    end
    send(BASE + 32'h14, acc);
    wait_rsp(at);
    e = sb.pop_front();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_inst !== e[31:0]) begin
      errors++;
      $display("FAIL coll_new got=%h want=%h v=%b",
               rsp_inst, e[31:0], rsp_valid);
    end
    tick();
  endtask

  task automatic test_reset_wait();
    int acc;
    bit seen;
    seen = 1'b0;
    send(BASE, acc);
    void'(sb.pop_front());
    #3 rst = 1'b1;
    #1 if (rsp_valid) seen = 1'b1;
    tick();
    #3 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    checks += 2;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_rsp got=%b want=0", seen);
    end
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_latency1();
    logic [32:0] e;
    checks++;
    if (req_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL lat1_ready got=%b want=1", req_ready1);
    end
    req_pc1    = BASE;
    req_valid1 = 1'b1;
    sb.push_back(exp_of(BASE));
    tick();
    req_valid1 = 1'b0;
    e = sb.pop_front();
    checks += 2;
    if (rsp_valid1 !== 1'b1 || rsp_inst1 !== e[31:0]) begin
      errors++;
      $display("FAIL lat1_rsp got=%h want=%h v=%b",
               rsp_inst1, e[31:0], rsp_valid1);
    end
    if (rsp_err1 !== 1'b0) begin
      errors++;
      $display("FAIL lat1_err got=%b want=0", rsp_err1);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_faults();
    test_backpressure();
    test_collision();
    test_reset_wait();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
